// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// With LOGIC_UNIT_FLAGS_EN defined, the result flags travel with the result.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_op;
  logic             in_chain;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] acc_out;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic             out_zero;
  logic             out_ones;
  logic             out_parity;
`endif

  modport master (
    output in_valid, in_a, in_b, in_op, in_chain, out_ready,
    input  in_ready, out_valid, out_data, acc_out
`ifdef LOGIC_UNIT_FLAGS_EN
    , input out_zero, out_ones, out_parity
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_chain, out_ready,
    output in_ready, out_valid, out_data, acc_out
`ifdef LOGIC_UNIT_FLAGS_EN
    , output out_zero, out_ones, out_parity
`endif
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined truth-table logic unit with chaining accumulator.
// Optional result flags (zero/ones/parity) enabled by LOGIC_UNIT_FLAGS_EN.

// One result bit: the opcode is a 4-entry truth table indexed by {a,b}.
module logic_unit_lane (
  input  logic [3:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  assign y = op[{a, b}];
endmodule

module logic_unit_pipe #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic           clk,
  input  logic           rst,
  logic_unit_pipe_if.slave bus
);
  logic             v1, v2;
  logic [WIDTH-1:0] a1, b1;
  logic [3:0]       op1;
  logic             chain1;
  logic [WIDTH-1:0] data2, acc;
  logic [WIDTH-1:0] a_eff, res;
  logic             adv2, in_ready, accept, xfer;

  assign adv2     = !v2 | bus.out_ready;
  assign in_ready = (!v1 | adv2) & !rst;
  assign accept   = bus.in_valid & in_ready;
  assign xfer     = v1 & adv2;

  // Operand stage data needs no reset: it is only consumed while v1 is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      a1     <= bus.in_a;
      b1     <= bus.in_b;
      op1    <= bus.in_op;
      chain1 <= bus.in_chain;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         v1 <= 1'b0;
    else if (accept) v1 <= 1'b1;
    else if (xfer)   v1 <= 1'b0;
  end

  // acc is written on the same edge as S2, so a chained beat directly
  // behind its producer sees the fresh result with no bubble.
  assign a_eff = chain1 ? acc : a1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic_unit_lane u_lane (
      .op (op1),
      .a  (a_eff[i]),
      .b  (b1[i]),
      .y  (res[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      data2 <= '0;
      acc   <= ACC_INIT;
    end else if (xfer) begin
      v2    <= 1'b1;
      data2 <= res;
      acc   <= res;
    end else if (bus.out_ready) begin
      v2    <= 1'b0;
    end
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  logic zero2, ones2, parity2;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero2   <= 1'b0;
      ones2   <= 1'b0;
      parity2 <= 1'b0;
    end else if (xfer) begin
      zero2   <= (res == '0);
      ones2   <= &res;
      parity2 <= ^res;
    end
  end

  assign bus.out_zero   = zero2;
  assign bus.out_ones   = ones2;
  assign bus.out_parity = parity2;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = v2;
  assign bus.out_data  = data2;
  assign bus.acc_out   = acc;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=16, ACC_INIT=0).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_logic_unit_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total = 0;

  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(W)) bus ();

  logic_unit_pipe #(.WIDTH(W), .ACC_INIT(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] op, input logic ch);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_chain = ch;
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] op);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case ({a[i], b[i]})
        2'b00: r[i] = op[0];
        2'b01: r[i] = op[1];
        2'b10: r[i] = op[2];
        default: r[i] = op[3];
      endcase
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 4'h0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    total++; if (bus.out_data !== 16'h0000) $display("FAIL reset_out_data got=%h exp=0000", bus.out_data); else pass_cnt++;
    total++; if (bus.acc_out !== 16'h0000) $display("FAIL reset_acc got=%h exp=0000", bus.acc_out); else pass_cnt++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); else pass_cnt++;
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_xor();
    bus.out_ready = 1'b1;
    drive(1'b1, 16'hF0F0, 16'hFF00, 4'b0110, 1'b0);
    tick();
    drive(1'b0, '0, '0, 4'h0, 1'b0);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL xor_early_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    tick();
    total++; if (bus.out_valid !== 1'b1) $display("FAIL xor_valid got=%b exp=1", bus.out_valid); else pass_cnt++;
    total++; if (bus.out_data !== 16'h0FF0) $display("FAIL xor_data got=%h exp=0ff0", bus.out_data); else pass_cnt++;
    total++; if (bus.acc_out !== 16'h0FF0) $display("FAIL xor_acc got=%h exp=0ff0", bus.acc_out); else pass_cnt++;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL xor_drain got=%b exp=0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_chain();
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h1234, 16'hFF00, 4'b1000, 1'b0);
    tick();
    drive(1'b1, 16'h0000, 16'h0034, 4'b1110, 1'b1);
    tick();
    drive(1'b0, '0, '0, 4'h0, 1'b0);
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1200)
      $display("FAIL chain_beat1 got=%b/%h exp=1/1200", bus.out_valid, bus.out_data); else pass_cnt++;
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1234)
      $display("FAIL chain_beat2 got=%b/%h exp=1/1234", bus.out_valid, bus.out_data); else pass_cnt++;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL chain_drain got=%b exp=0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0001, 16'h0000, 4'b1100, 1'b0);
    tick();
    drive(1'b1, 16'h0002, 16'h0000, 4'b1100, 1'b0);
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready2 got=%b exp=1", bus.in_ready); else pass_cnt++;
    tick();
    drive(1'b1, 16'h0003, 16'h0000, 4'b1100, 1'b0);
    #1;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_full got=%b exp=0", bus.in_ready); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0001 || bus.in_ready !== 1'b0)
        $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/0001/0", k, bus.out_valid, bus.out_data, bus.in_ready);
      else pass_cnt++;
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
    tick();
    drive(1'b0, '0, '0, 4'h0, 1'b0);
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0002)
      $display("FAIL bp_order2 got=%b/%h exp=1/0002", bus.out_valid, bus.out_data); else pass_cnt++;
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0003)
      $display("FAIL bp_order3 got=%b/%h exp=1/0003", bus.out_valid, bus.out_data); else pass_cnt++;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_constants();
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h1234, 16'h5678, 4'b1111, 1'b0);
    tick();
    drive(1'b1, 16'hFFFF, 16'hA5A5, 4'b0000, 1'b0);
    tick();
    drive(1'b0, '0, '0, 4'h0, 1'b0);
    total++; if (bus.out_data !== 16'hFFFF) $display("FAIL const_ones got=%h exp=ffff", bus.out_data); else pass_cnt++;
`ifdef LOGIC_UNIT_FLAGS_EN
    total++; if ({bus.out_zero, bus.out_ones, bus.out_parity} !== 3'b010)
      $display("FAIL flags_ones got=%b exp=010", {bus.out_zero, bus.out_ones, bus.out_parity}); else pass_cnt++;
`endif
    tick();
    total++; if (bus.out_data !== 16'h0000 || bus.out_valid !== 1'b1)
      $display("FAIL const_zero got=%b/%h exp=1/0000", bus.out_valid, bus.out_data); else pass_cnt++;
`ifdef LOGIC_UNIT_FLAGS_EN
    total++; if ({bus.out_zero, bus.out_ones, bus.out_parity} !== 3'b100)
      $display("FAIL flags_zero got=%b exp=100", {bus.out_zero, bus.out_ones, bus.out_parity}); else pass_cnt++;
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 16'h0000, 4'b1100, 1'b0);
    tick();
    drive(1'b1, 16'h5555, 16'h0000, 4'b1100, 1'b0);
    tick();
    drive(1'b0, '0, '0, 4'h0, 1'b0);
    total++; if (bus.acc_out !== 16'hAAAA) $display("FAIL mid_acc_pre got=%h exp=aaaa", bus.acc_out); else pass_cnt++;
    rst = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.acc_out !== 16'h0000 || bus.out_data !== 16'h0000 || bus.in_ready !== 1'b0)
      $display("FAIL mid_reset got=%b/%h/%h/%b exp=0/0000/0000/0", bus.out_valid, bus.acc_out, bus.out_data, bus.in_ready);
    else pass_cnt++;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 16'hFFFF, 16'hABCD, 4'b1100, 1'b1);
    tick();
    drive(1'b0, '0, '0, 4'h0, 1'b0);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_no_stale got=%b exp=0", bus.out_valid); else pass_cnt++;
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0000)
      $display("FAIL mid_chain got=%b/%h exp=1/0000", bus.out_valid, bus.out_data); else pass_cnt++;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_drain got=%b exp=0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_throughput();
    logic [W-1:0] ea [8];
    logic [W-1:0] eb [8];
    logic [3:0]   eo [8];
    for (int i = 0; i < 8; i++) begin
      ea[i] = W'($urandom);
      eb[i] = W'($urandom);
      eo[i] = 4'($urandom_range(0, 15));
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        drive(1'b1, ea[i], eb[i], eo[i], 1'b0);
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL tp_ready%0d got=%b exp=1", i, bus.in_ready); else pass_cnt++;
      end else begin
        drive(1'b0, '0, '0, 4'h0, 1'b0);
      end
      tick();
      if (i >= 1) begin
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== model(ea[i-1], eb[i-1], eo[i-1]))
          $display("FAIL tp_beat%0d got=%b/%h exp=1/%h", i-1, bus.out_valid, bus.out_data, model(ea[i-1], eb[i-1], eo[i-1]));
        else pass_cnt++;
      end
    end
    total++; if (bus.acc_out !== model(ea[7], eb[7], eo[7]))
      $display("FAIL tp_acc got=%h exp=%h", bus.acc_out, model(ea[7], eb[7], eo[7])); else pass_cnt++;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL tp_drain got=%b exp=0", bus.out_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_xor();
    test_chain();
    test_backpressure();
    test_constants();
    test_reset_mid();
    test_throughput();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
